// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: turns a stream of configuration words into the serial
// bit stream at the head of the tile ccff chain. Each word is shifted out MSB
// first with a registered chain-clock enable, and the session is checked against
// CHAIN_LEN so that a stream which is too short or too long is reported.
module ccff_bitstream_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  bit_cnt
);

  // Width of the per-word remaining-bit counter (must hold WORD_W itself).
  localparam int unsigned WL_W = $clog2(WORD_W + 1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [WL_W-1:0]  WL_FULL  = WL_W'(WORD_W);
  localparam logic [WL_W-1:0]  WL_ONE   = WL_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [WL_W-1:0]    word_left_q, word_left_d;
  logic               last_q, last_d;
  logic               head_q, head_d;
  logic               clk_en_q, clk_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  // Bit count after the bit being shifted now, saturating at CHAIN_LEN.
  logic [CNT_W-1:0]   bit_cnt_inc;
  // The bit shifted now fills the chain / empties the current word.
  logic               chain_full;
  logic               word_empty;

  // Saturating increment and the two SHIFT exit conditions.
  assign bit_cnt_inc = (bit_cnt_q >= CNT_FULL) ? CNT_FULL : (bit_cnt_q + CNT_W'(1));
  assign chain_full  = (bit_cnt_inc == CNT_FULL);
  assign word_empty  = (word_left_q == WL_ONE);

  // Word handshake is only offered while fetching.
  assign s_ready = (state_q == ST_FETCH);

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    word_left_d = word_left_q;
    last_d      = last_q;
    head_d      = 1'b0;
    clk_en_d    = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    bit_cnt_d   = bit_cnt_q;

    if (abort) begin
      state_d     = ST_IDLE;
      shreg_d     = '0;
      word_left_d = '0;
      last_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = ERR_NONE;
      bit_cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_d   = ST_FETCH;
            done_d    = 1'b0;
            err_d     = ERR_NONE;
            bit_cnt_d = '0;
          end
        end

        ST_FETCH: begin
          if (s_valid) begin
            shreg_d     = s_data;
            word_left_d = WL_FULL;
            last_d      = s_last;
            state_d     = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          head_d      = shreg_q[WORD_W-1];
          clk_en_d    = 1'b1;
          shreg_d     = {shreg_q[WORD_W-2:0], 1'b0};
          word_left_d = word_left_q - WL_ONE;
          bit_cnt_d   = bit_cnt_inc;
          // Chain-full takes precedence; leftover bits of the word are pad.
          if (chain_full) begin
            if (last_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_ERROR;
              err_d   = ERR_OVER;
            end
          end else if (word_empty) begin
            if (last_q) begin
              state_d = ST_ERROR;
              err_d   = ERR_UNDER;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // busy is registered from the next state so it tracks FETCH/SHIFT exactly.
  assign busy_d = (state_d == ST_FETCH) || (state_d == ST_SHIFT);

  // State register.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      shreg_q     <= '0;
      word_left_q <= '0;
      last_q      <= 1'b0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
      bit_cnt_q   <= '0;
    end else begin
      shreg_q     <= shreg_d;
      word_left_q <= word_left_d;
      last_q      <= last_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 40-bit chain model plus a bit-queue model
// of the expected serial stream, checked every cycle, with directed sessions.
module tb_ccff_bitstream_loader;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CHAIN_LEN = 40;
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);

  logic              prog_clk = 1'b0;
  logic              pReset_n;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              ccff_head;
  logic              ccff_clk_en;
  logic              busy;
  logic              done;
  logic [1:0]        err;
  logic [CNT_W-1:0]  bit_cnt;

  int tests = 0;
  int fails = 0;

  // Model state.
  logic [CHAIN_LEN-1:0] chain = '0;
  bit   exp_q[$];
  int   pulses   = 0;
  int   sess_id  = 0;
  int   seen_sess = 0;
  int   hs_age   = 0;

  ccff_bitstream_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .prog_clk   (prog_clk),
    .pReset_n   (pReset_n),
    .start      (start),
    .abort      (abort),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .ccff_head  (ccff_head),
    .ccff_clk_en(ccff_clk_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bit_cnt    (bit_cnt)
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain: captures ccff_head on every enabled prog_clk edge.
  always @(posedge prog_clk) begin
    if (ccff_clk_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_start();
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b1;
    sess_id++;
    tick();
    start = 1'b0;
  endtask

  // Offer one word; gap>0 keeps s_valid low for gap cycles of FETCH first.
  task automatic send_word(input logic [WORD_W-1:0] d, input logic l,
                           input bit hold, input int gap);
    int n;
    s_data  = d;
    s_last  = l;
    s_valid = (gap == 0);
    n = 0;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    chk("ready_wait", s_ready, 1);
    if (gap != 0) begin
      repeat (gap) tick();
      s_valid = 1'b1;
    end
    tick();
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", busy, 0);
    tick();
    tick();
  endtask

  // Two-word clean session: 40 bits of 0xA5A50F0F_C3, rest of word 2 is pad.
  task automatic run_nominal(input string tag, input int gap);
    do_start();
    send_word(32'hA5A5_0F0F, 1'b0, gap == 0, gap);
    send_word(32'hC3FF_FFFF, 1'b1, 1'b0, gap);
    wait_idle();
    chk({tag, "_done"},    done, 1);
    chk({tag, "_err"},     err, 2'b00);
    chk({tag, "_bit_cnt"}, bit_cnt, 40);
    chk({tag, "_pulses"},  pulses, 40);
    chk({tag, "_chain"},   chain, 40'hA5A50F0FC3);
    chk({tag, "_s_ready"}, s_ready, 0);
  endtask

  initial begin
    pReset_n = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    s_last   = 1'b0;

    fork
      // Per-cycle compare against the bit-queue model.
      begin : mon
        forever begin
          @(negedge prog_clk);
          if (sess_id != seen_sess) begin
            seen_sess = sess_id;
            exp_q.delete();
            pulses = 0;
          end
          if (!pReset_n) begin
            hs_age = 0;
          end else begin
            if (hs_age == 1) begin
              chk("lat_bubble", ccff_clk_en, 0);
              hs_age = 2;
            end else if (hs_age == 2) begin
              chk("lat_first_en", ccff_clk_en, 1);
              hs_age = 0;
            end
            if (s_valid && s_ready && !abort) begin
              for (int i = WORD_W - 1; i >= 0; i--) exp_q.push_back(s_data[i]);
              hs_age = 1;
            end
            if (ccff_clk_en) begin
              chk("en_expected", exp_q.size() != 0, 1);
              if (exp_q.size() != 0) chk("head_bit", ccff_head, exp_q.pop_front());
              pulses++;
              chk("bit_cnt_track", bit_cnt, pulses);
            end else begin
              chk("head_idle", ccff_head, 0);
            end
            chk("done_err_excl", done && (err != 2'b00), 0);
            chk("ready_in_busy", s_ready && !busy, 0);
            chk("busy_clean", busy && (done || err != 2'b00), 0);
            chk("err_code", err == 2'b11, 0);
          end
        end
      end

      begin : stim
        // Power-on reset.
        #2;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_head",    ccff_head, 0);
        chk("rst_en",      ccff_clk_en, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_done",    done, 0);
        chk("rst_err",     err, 2'b00);
        chk("rst_bit_cnt", bit_cnt, 0);
        tick();
        tick();
        pReset_n = 1'b1;
        tick();

        // Nominal back-to-back session.
        run_nominal("nom", 0);

        // Underrun: one last word of 32 bits into a 40-bit chain.
        do_start();
        send_word(32'h1234_5678, 1'b1, 1'b0, 0);
        wait_idle();
        chk("und_err",     err, 2'b01);
        chk("und_done",    done, 0);
        chk("und_busy",    busy, 0);
        chk("und_s_ready", s_ready, 0);
        chk("und_pulses",  pulses, 32);
        chk("und_bit_cnt", bit_cnt, 32);
        chk("und_chain",   chain[31:0], 32'h1234_5678);

        // Overrun: chain fills before any last word.
        do_start();
        send_word(32'h0F0F_1234, 1'b0, 1'b1, 0);
        send_word(32'hDEAD_BEEF, 1'b0, 1'b1, 0);
        s_data = 32'h1111_1111;
        wait_idle();
        chk("ovr_err",     err, 2'b10);
        chk("ovr_done",    done, 0);
        chk("ovr_pulses",  pulses, 40);
        chk("ovr_bit_cnt", bit_cnt, 40);
        chk("ovr_chain",   chain, 40'h0F0F1234DE);
        for (int i = 0; i < 5; i++) begin
          tick();
          chk("ovr_s_ready", s_ready, 0);
        end
        s_valid = 1'b0;

        // Backpressure: 5-cycle valid gaps only stretch the enable pattern.
        run_nominal("bp", 5);

        // Abort at bit 17.
        begin
          int n;
          do_start();
          send_word(32'hA5A5_0F0F, 1'b0, 1'b1, 0);
          n = 0;
          while (bit_cnt != 17 && n < 100) begin
            tick();
            n++;
          end
          chk("abt_at17", bit_cnt, 17);
          abort   = 1'b1;
          s_valid = 1'b0;
          tick();
          abort = 1'b0;
          chk("abt_busy",    busy, 0);
          chk("abt_en",      ccff_clk_en, 0);
          chk("abt_bit_cnt", bit_cnt, 0);
          chk("abt_done",    done, 0);
          chk("abt_err",     err, 2'b00);
          chk("abt_s_ready", s_ready, 0);
          tick();
          run_nominal("abt_rst", 0);
        end

        // Async reset in the middle of SHIFT, then full restart.
        do_start();
        send_word(32'hA5A5_0F0F, 1'b0, 1'b1, 0);
        repeat (10) tick();
        #2;
        pReset_n = 1'b0;
        #1;
        chk("mrst_s_ready", s_ready, 0);
        chk("mrst_head",    ccff_head, 0);
        chk("mrst_en",      ccff_clk_en, 0);
        chk("mrst_busy",    busy, 0);
        chk("mrst_done",    done, 0);
        chk("mrst_err",     err, 2'b00);
        chk("mrst_bit_cnt", bit_cnt, 0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
        tick();
        pReset_n = 1'b1;
        tick();
        run_nominal("mrst_restart", 0);
      end
    join_any

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
